// File: rtl/mem_req_bridge.sv
// Registered request/response bridge between the CPU memory port and the SoC bus.
// Optional hung-access abort with fault reporting: define MEM_REQ_BRIDGE_TIMEOUT_EN.
module mem_req_bridge #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    state_t      r_state, w_state_next;
    logic        r_cpu_ready, w_cpu_ready_next;
    logic [31:0] r_cpu_rdata, w_cpu_rdata_next;
    logic        r_bus_valid, w_bus_valid_next;
    logic [31:0] r_bus_addr, w_bus_addr_next;
    logic [31:0] r_bus_wdata, w_bus_wdata_next;
    logic [3:0]  r_bus_wstrb, w_bus_wstrb_next;

`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_cpu_fault, w_cpu_fault_next;
    logic             w_expired;

    assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cpu_fault = r_cpu_fault;
`else
    assign cpu_fault = 1'b0;
`endif

    always_comb begin
        w_state_next     = r_state;
        w_cpu_ready_next = 1'b0;
        w_cpu_rdata_next = r_cpu_rdata;
        w_bus_valid_next = r_bus_valid;
        w_bus_addr_next  = r_bus_addr;
        w_bus_wdata_next = r_bus_wdata;
        w_bus_wstrb_next = r_bus_wstrb;
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
        w_cnt_next       = r_cnt;
        w_cpu_fault_next = r_cpu_fault;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (cpu_valid) begin
                    w_bus_addr_next  = cpu_addr;
                    w_bus_wdata_next = cpu_wdata;
                    w_bus_wstrb_next = cpu_wstrb;
                    w_bus_valid_next = 1'b1;
                    w_state_next     = ST_REQ;
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
                    w_cnt_next       = '0;
                    w_cpu_fault_next = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                // bus_ready takes priority over an expiring timeout
                if (bus_ready) begin
                    if (r_bus_wstrb == 4'd0) begin
                        w_cpu_rdata_next = bus_rdata;
                    end
                    w_bus_valid_next = 1'b0;
                    w_cpu_ready_next = 1'b1;
                    w_state_next     = ST_DONE;
                end
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
                else if (w_expired) begin
                    w_bus_valid_next = 1'b0;
                    w_cpu_fault_next = 1'b1;
                    w_cpu_rdata_next = '0;
                    w_cpu_ready_next = 1'b1;
                    w_state_next     = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_cpu_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_bus_valid <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
            r_cnt       <= '0;
            r_cpu_fault <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_cpu_ready <= w_cpu_ready_next;
            r_cpu_rdata <= w_cpu_rdata_next;
            r_bus_valid <= w_bus_valid_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_wdata <= w_bus_wdata_next;
            r_bus_wstrb <= w_bus_wstrb_next;
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
            r_cnt       <= w_cnt_next;
            r_cpu_fault <= w_cpu_fault_next;
`endif
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign bus_valid = r_bus_valid;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_mem_req_bridge.sv
// Randomized bench for mem_req_bridge; the bench plays the bus slave and predicts
// completion latency, read data and fault from the access rules.
module tb_mem_req_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    logic [31:0] exp_rdata;

    mem_req_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cpu_valid (cpu_valid),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_rdata (cpu_rdata),
        .cpu_fault (cpu_fault),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access. waits = bus wait cycles before bus_ready (large = never).
    // b2b: inputs presented during the previous DONE; hold: keep cpu_valid high at the end.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int waits, input logic [31:0] rd,
                          input bit b2b, input bit hold, input bit mutate);
        int req_cycles;
        bit fault;
        bit done;
        int k;
`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
        fault = (waits >= TO);
`else
        fault = 1'b0;
`endif
        req_cycles = fault ? TO : waits + 1;
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        cpu_wstrb = ws;
        if (b2b) begin
            tick();
            check_val("b2b_idle_bus_valid", 32'(bus_valid), 32'd0);
            check_val("b2b_idle_cpu_ready", 32'(cpu_ready), 32'd0);
        end
        tick();
        k    = 1;
        done = 1'b0;
        while (!done && k <= 40) begin
            if (cpu_ready) begin
                done = 1'b1;
            end else begin
                check_val("req_bus_valid", 32'(bus_valid), 32'd1);
                check_val("req_bus_addr", bus_addr, a);
                check_val("req_bus_wdata", bus_wdata, wd);
                check_val("req_bus_wstrb", 32'(bus_wstrb), 32'(ws));
                if (mutate && k == 2) begin
                    cpu_addr  = 32'hFFFF_FFFC;
                    cpu_wdata = $urandom;
                    cpu_wstrb = ~ws;
                end
                bus_ready = (k - 1 == waits);
                bus_rdata = bus_ready ? rd : $urandom;
                tick();
                k++;
            end
        end
        bus_ready = 1'b0;
        if (!done) begin
            check_val("completion_seen", 32'(cpu_ready), 32'd1);
        end else begin
            if (fault)
                exp_rdata = 32'd0;
            else if (ws == 4'd0)
                exp_rdata = rd;
            check_val("latency", 32'(k), 32'(req_cycles + 1));
            check_val("done_rdata", cpu_rdata, exp_rdata);
            check_val("done_fault", 32'(cpu_fault), 32'(fault));
            check_val("done_bus_valid", 32'(bus_valid), 32'd0);
        end
        n_txn++;
        $display("txn %0d addr=%08h wstrb=%h waits=%0d lat=%0d rdata=%08h fault=%0b",
                 n_txn, a, ws, waits, k, cpu_rdata, cpu_fault);
        if (!hold) begin
            cpu_valid = 1'b0;
            tick();
            check_val("single_pulse", 32'(cpu_ready), 32'd0);
            check_val("idle_bus_valid", 32'(bus_valid), 32'd0);
        end
    endtask

    initial begin
        bit prev_hold;
        bit hold;
        logic [3:0] ws;
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        bus_ready = 1'b0;
        bus_rdata = '0;
        exp_rdata = '0;
        tick();
        tick();
        check_val("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check_val("rst_cpu_fault", 32'(cpu_fault), 32'd0);
        check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_val("rst_bus_valid", 32'(bus_valid), 32'd0);
        check_val("rst_bus_addr", bus_addr, 32'd0);
        check_val("rst_bus_wdata", bus_wdata, 32'd0);
        check_val("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        resetn = 1'b1;
        tick();

        access(32'h8000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        access(32'h1000_0004, 32'h1234_5678, 4'b0011, 3, $urandom, 1'b0, 1'b0, 1'b0);
        access(32'h2000_0000, 32'hCAFE_F00D, 4'hF, 4, $urandom, 1'b0, 1'b0, 1'b1);
        access(32'h3000_0008, 32'h0, 4'h0, 1, 32'hA5A5_5A5A, 1'b0, 1'b1, 1'b0);
        access(32'h3000_000C, 32'h0, 4'h0, 0, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0);

        // Reset pulse in the middle of a waiting access
        cpu_valid = 1'b1;
        cpu_addr  = 32'h4000_0000;
        cpu_wstrb = 4'h0;
        tick();
        bus_ready = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        check_val("rstmid_bus_valid_async", 32'(bus_valid), 32'd0);
        check_val("rstmid_cpu_ready", 32'(cpu_ready), 32'd0);
        cpu_valid = 1'b0;
        tick();
        check_val("rstmid_cpu_rdata", cpu_rdata, 32'd0);
        check_val("rstmid_bus_addr", bus_addr, 32'd0);
        resetn    = 1'b1;
        exp_rdata = 32'd0;
        tick();
        check_val("rstmid_no_pulse", 32'(cpu_ready), 32'd0);
        access(32'h4000_0010, 32'h0, 4'h0, 2, 32'h1357_9BDF, 1'b0, 1'b0, 1'b0);

        prev_hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ws   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            hold = (i == 29) ? 1'b0 : 1'($urandom_range(0, 1));
            access($urandom, $urandom, ws, $urandom_range(0, 5), $urandom, prev_hold, hold, 1'($urandom_range(0, 1)));
            prev_hold = hold;
        end

`ifdef MEM_REQ_BRIDGE_TIMEOUT_EN
        access(32'h5000_0000, 32'h0, 4'h0, 1000, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
        access(32'h5000_0004, 32'h0, 4'h0, TO - 1, 32'h3333_4444, 1'b0, 1'b0, 1'b0);
        access(32'h5000_0008, 32'h9999_9999, 4'hF, 1000, 32'h0, 1'b0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
